// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential signed multiplier.
//   state_t : sequencer states (IDLE, CLR, ADD, SHIFT, DONE)
//   WIDTH   : default operand width
//   CNT_W   : iteration counter width for the default operand width
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = $clog2(WIDTH);

endpackage

// File: rtl/add_sub_ext.sv
// add_sub_ext: N-bit ripple-carry add/subtract built from full_adder cells.
//   a    : first operand
//   b    : second operand
//   fn   : 0 = a + b, 1 = a - b (inverts b and injects carry-in)
//   s    : result modulo 2^N
//   cout : carry out of the top cell
module add_sub_ext #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         fn,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] bx;
    logic [N:0]   c;

    assign bx   = b ^ {N{fn}};
    assign c[0] = fn;
    assign cout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (bx[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mult_seq.sv
// mult_seq: sequential signed shift-add multiplier.
// Holds multiplicand M, accumulator {X,A} and multiplier B; runs WIDTH
// add/shift iterations to form the 2*WIDTH-bit signed product in {A,B}.
//   Clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   Start   : begin a multiply (sampled in IDLE only)
//   Load_B  : load S into B (sampled in IDLE only)
//   S       : operand bus for multiplicand and multiplier
//   Busy    : high in CLR, ADD and SHIFT
//   Done    : one-cycle pulse in DONE
//   X       : accumulator sign-extension bit
//   A       : upper product half
//   B       : lower product half / multiplier
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Load_B,
    input  logic [WIDTH-1:0] S,
    output logic             Busy,
    output logic             Done,
    output logic             X,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state;
    state_t         state_nx;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]  count;
    logic           last;
    logic [WIDTH:0] sum;
    logic           add_cout_unused;

    assign last = (count == LAST);

    // The final iteration weighs the multiplier sign bit, so it subtracts.
    add_sub_ext #(
        .N(WIDTH + 1)
    ) u_add_sub (
        .a   ({A[WIDTH-1], A}),
        .b   ({m[WIDTH-1], m}),
        .fn  (last),
        .s   (sum),
        .cout(add_cout_unused)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = CLR;
                end
            end
            CLR: begin
                Busy     = 1'b1;
                state_nx = ADD;
            end
            ADD: begin
                Busy     = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                Busy     = 1'b1;
                state_nx = last ? DONE : ADD;
            end
            DONE: begin
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            X     <= 1'b0;
            A     <= '0;
            B     <= '0;
            m     <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load_B) begin
                        B <= S;
                    end
                    if (Start) begin
                        m <= S;
                    end
                end
                CLR: begin
                    X     <= 1'b0;
                    A     <= '0;
                    count <= '0;
                end
                ADD: begin
                    if (B[0]) begin
                        {X, A} <= sum;
                    end
                end
                SHIFT: begin
                    // Arithmetic right shift of {X,A,B}; X keeps its value.
                    A     <= {X, A[WIDTH-1:1]};
                    B     <= {A[0], B[WIDTH-1:1]};
                    count <= count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

    localparam int W = 8;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic         Load_B;
    logic [W-1:0] S;
    logic         Busy;
    logic         Done;
    logic         X;
    logic [W-1:0] A;
    logic [W-1:0] B;

    int vectors;
    int miscompares;
    logic [W-1:0] mdl_b;

    mult_seq #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Start  (Start),
        .Load_B (Load_B),
        .S      (S),
        .Busy   (Busy),
        .Done   (Done),
        .X      (X),
        .A      (A),
        .B      (B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input logic [W-1:0] v);
        @(negedge Clk);
        Load_B = 1'b1;
        S      = v;
        @(negedge Clk);
        Load_B = 1'b0;
        mdl_b  = v;
        check("load_b", B, v);
    endtask

    // mode 0: plain run; 1: Start/Load_B/S disturbed while busy; 2: reset at cycle 10
    task automatic mult(input logic [W-1:0] s_val, input logic with_load, input int mode);
        logic [W-1:0] mm;
        logic [W-1:0] bb;
        logic [2*W-1:0] prod;
        int p;
        int n;
        mm = s_val;
        if (with_load) mdl_b = s_val;
        bb = mdl_b;
        p    = int'($signed(mm)) * int'($signed(bb));
        prod = p[2*W-1:0];
        @(negedge Clk);
        S      = s_val;
        Start  = 1'b1;
        Load_B = with_load;
        @(negedge Clk);
        Start  = 1'b0;
        Load_B = 1'b0;
        n = 1;
        check("busy_clr", Busy, 1);
        while (Done !== 1'b1 && n < 100) begin
            if (mode == 1) begin
                S = W'($urandom);
                if (n == 5) Start = 1'b1;
                if (n == 6) Start = 1'b0;
                if (n == 9) Load_B = 1'b1;
                if (n == 10) Load_B = 1'b0;
            end
            if (mode == 2 && n == 10) begin
                Reset_n = 1'b0;
                #1;
                check("abort_x", X, 0);
                check("abort_a", A, 0);
                check("abort_b", B, 0);
                check("abort_busy", Busy, 0);
                check("abort_done", Done, 0);
                @(negedge Clk);
                check("abort_done_hold", Done, 0);
                Reset_n = 1'b1;
                mdl_b   = '0;
                @(negedge Clk);
                check("abort_idle_done", Done, 0);
                check("abort_idle_busy", Busy, 0);
                return;
            end
            @(negedge Clk);
            n++;
        end
        check("done_cycle", n, 2 * W + 2);
        check("busy_in_done", Busy, 0);
        check("result_a", A, prod[2*W-1:W]);
        check("result_b", B, prod[W-1:0]);
        check("result_x", X, prod[2*W-1]);
        mdl_b = prod[W-1:0];
        // Load_B presented only during DONE must be ignored.
        Load_B = 1'b1;
        S      = ~prod[W-1:0];
        @(negedge Clk);
        Load_B = 1'b0;
        check("done_pulse_end", Done, 0);
        check("idle_busy", Busy, 0);
        check("hold_b", B, prod[W-1:0]);
        check("hold_a", A, prod[2*W-1:W]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mdl_b       = '0;
        Reset_n     = 1'b0;
        Start       = 1'b0;
        Load_B      = 1'b0;
        S           = '0;
        repeat (3) @(negedge Clk);
        check("rst_x", X, 0);
        check("rst_a", A, 0);
        check("rst_b", B, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset_n = 1'b1;

        load_b(8'h03);
        mult(8'hF9, 1'b0, 0);
        load_b(8'h80);
        mult(8'h80, 1'b0, 0);
        mult(8'h05, 1'b1, 0);
        load_b(8'h06);
        mult(8'hFB, 1'b0, 1);
        load_b(8'h11);
        mult(8'h23, 1'b0, 2);
        load_b(8'h09);
        mult(8'h07, 1'b0, 0);
        load_b(8'h00);
        mult(8'hA5, 1'b0, 0);
        load_b(8'hFF);
        mult(8'h7F, 1'b0, 0);
        load_b(8'h7F);
        mult(8'h80, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) load_b(W'($urandom));
            mult(W'($urandom), 1'($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
